// File: rtl/win_pingpong_fb_if.sv
// Pixel-stream input, display-side read port and status signals of the ping-pong window buffer.
// master = stream source / display reader, slave = frame buffer.
interface win_pingpong_fb_if #(
    parameter int DATA_W = 1,
    parameter int ADDR_W = 16
);
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              din_sop;
    logic              din_eop;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              rd_done;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              frame_rdy;
    logic              rd_bank;
    logic              frame_drop;
    logic              err_len;

    modport master (
        output din, din_vld, din_sop, din_eop, rd_addr, rd_en, rd_done,
        input  dout, dout_vld, frame_rdy, rd_bank, frame_drop, err_len
    );

    modport slave (
        input  din, din_vld, din_sop, din_eop, rd_addr, rd_en, rd_done,
        output dout, dout_vld, frame_rdy, rd_bank, frame_drop, err_len
    );
endinterface

// File: rtl/win_pingpong_fb.sv
// Two-bank window frame buffer: captures a rectangular window of each frame into a free bank
// while the display reader consumes the other; drops frames when no bank is free.
module win_pingpong_fb #(
    parameter int DATA_W = 1,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int WIN_X  = 160,
    parameter int WIN_Y  = 120,
    parameter int WIN_W  = 320,
    parameter int WIN_H  = 200,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    win_pingpong_fb_if.slave  bus
);
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int DEPTH = WIN_W * WIN_H;
    localparam int XW    = $clog2(IMG_W + 1);
    localparam int YW    = $clog2(IMG_H + 2);
    localparam int CW    = $clog2(TOTAL + 2);

    localparam logic [XW-1:0] X_LO   = XW'(WIN_X);
    localparam logic [XW-1:0] X_HI   = XW'(WIN_X + WIN_W);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LO   = YW'(WIN_Y);
    localparam logic [YW-1:0] Y_HI   = YW'(WIN_Y + WIN_H);
    localparam logic [CW-1:0] C_LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] C_END  = CW'(TOTAL);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DROP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_waddr;
    logic [1:0]        r_full;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic              r_frame_drop;
    logic              r_err_len;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_vld;
    logic [DATA_W-1:0] r_mem0 [DEPTH];
    logic [DATA_W-1:0] r_mem1 [DEPTH];

    logic              w_sop;
    logic              w_start;
    logic              w_active;
    logic              w_drop;
    logic              w_sop_err;
    logic              w_eop_act;
    logic              w_complete;
    logic              w_len_err;
    logic              w_in_win;
    logic              w_we;
    logic [XW-1:0]     w_cx;
    logic [YW-1:0]     w_cy;
    logic [CW-1:0]     w_ccnt;
    logic [ADDR_W-1:0] w_cwaddr;
    logic [1:0]        w_full_nxt;
    logic              w_rd_hit;
    logic              w_rd_release;

    assign w_sop        = bus.din_vld & bus.din_sop;
    assign w_rd_hit     = bus.rd_en & r_full[r_rd_ptr];
    assign w_rd_release = bus.rd_done & r_full[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // A sop beat (from IDLE or restarting a capture) is treated as pixel (0,0) of a fresh frame.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_active    = 1'b0;
        w_drop      = 1'b0;
        w_sop_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sop) begin
                    if (!r_full[r_wr_ptr]) begin
                        w_start     = 1'b1;
                        w_active    = 1'b1;
                        w_state_nxt = S_CAPTURE;
                    end else begin
                        w_drop      = 1'b1;
                        w_state_nxt = bus.din_eop ? S_IDLE : S_DROP;
                    end
                end
            end
            S_CAPTURE: begin
                if (bus.din_vld) begin
                    w_active = 1'b1;
                    if (bus.din_sop) begin
                        w_start   = 1'b1;
                        w_sop_err = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (bus.din_vld && bus.din_eop) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_cx       = w_start ? '0 : r_x;
        w_cy       = w_start ? '0 : r_y;
        w_ccnt     = w_start ? '0 : r_cnt;
        w_cwaddr   = w_start ? '0 : r_waddr;
        w_in_win   = (w_cx >= X_LO) && (w_cx < X_HI) && (w_cy >= Y_LO) && (w_cy < Y_HI);
        w_we       = w_active && (w_ccnt < C_END) && w_in_win;
        w_eop_act  = w_active && bus.din_eop;
        w_complete = w_eop_act && (w_ccnt == C_LAST);
        w_len_err  = w_sop_err || (w_eop_act && (w_ccnt != C_LAST));
        if (w_eop_act) w_state_nxt = S_IDLE;
    end

    // Completion and release always target different banks, so both may apply in one cycle.
    always_comb begin
        w_full_nxt = r_full;
        if (w_complete)   w_full_nxt[r_wr_ptr] = 1'b1;
        if (w_rd_release) w_full_nxt[r_rd_ptr] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_cnt        <= '0;
            r_waddr      <= '0;
            r_full       <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_frame_drop <= 1'b0;
            r_err_len    <= 1'b0;
        end else begin
            if (w_active) begin
                r_x     <= (w_cx == X_LAST) ? '0 : w_cx + 1'b1;
                r_y     <= (w_cx == X_LAST) ? w_cy + 1'b1 : w_cy;
                r_cnt   <= (w_ccnt == C_END) ? w_ccnt : w_ccnt + 1'b1;
                r_waddr <= w_we ? w_cwaddr + 1'b1 : w_cwaddr;
            end
            r_full       <= w_full_nxt;
            r_wr_ptr     <= r_wr_ptr ^ w_complete;
            r_rd_ptr     <= r_rd_ptr ^ w_rd_release;
            r_frame_drop <= w_drop;
            r_err_len    <= w_len_err;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_we && !r_wr_ptr) r_mem0[w_cwaddr] <= bus.din;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_we && r_wr_ptr) r_mem1[w_cwaddr] <= bus.din;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= w_rd_hit;
            if (w_rd_hit) r_dout <= r_rd_ptr ? r_mem1[bus.rd_addr] : r_mem0[bus.rd_addr];
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_vld   = r_dout_vld;
    assign bus.frame_rdy  = r_full[r_rd_ptr];
    assign bus.rd_bank    = r_rd_ptr;
    assign bus.frame_drop = r_frame_drop;
    assign bus.err_len    = r_err_len;
endmodule

// File: tb/tb_win_pingpong_fb.sv
// Bench for win_pingpong_fb: frame scenario table, randomized frames against a queue-of-frames
// reference model, and hand-written sequences for timing, coincident release and reset.
module tb_win_pingpong_fb;
    localparam int DW   = 8;
    localparam int IW   = 8;
    localparam int IH   = 6;
    localparam int WX   = 2;
    localparam int WY   = 1;
    localparam int WW   = 4;
    localparam int WH   = 3;
    localparam int AW   = 4;
    localparam int NPIX = WW * WH;
    localparam int TOT  = IW * IH;

    typedef logic [DW-1:0] bank_t [NPIX];

    typedef struct {
        bit pre_done;
        int len;
        int sop_at;
        int base;
        int gap;
        bit exp_rdy;
        bit exp_bank;
        int exp_drop;
        int exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    win_pingpong_fb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    win_pingpong_fb #(
        .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN_X(WX), .WIN_Y(WY),
        .WIN_W(WW), .WIN_H(WH), .ADDR_W(AW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    n_drop   = 0;
    int    n_err    = 0;
    int    cyc      = 0;
    bank_t mdl_q[$];
    int    mdl_rd   = 0;
    vec_t  tbl[9];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_drop) n_drop++;
            if (bus.err_len)    n_err++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.din_vld = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0;
            bus.rd_en = 1'b0;   bus.rd_done = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic s, input logic e,
                              input int gap, input logic rdd);
        bit gap_now;
        @(negedge clk);
        cyc++;
        gap_now = (gap == 1 && (cyc % 3) == 0) || (gap == 2 && $urandom_range(0, 2) == 0);
        if (gap_now) begin
            bus.din     = DW'($urandom);
            bus.din_vld = 1'b0;
            bus.din_sop = 1'($urandom);
            bus.din_eop = 1'($urandom);
            bus.rd_done = 1'b0;
            @(negedge clk);
            cyc++;
        end
        bus.din     = d;
        bus.din_vld = 1'b1;
        bus.din_sop = s;
        bus.din_eop = e;
        bus.rd_done = rdd;
    endtask

    task automatic send_frame(input int len, input int sop_at, input int base, input int gap,
                              input bit done_on_eop);
        for (int k = 0; k < sop_at; k++)
            drive_beat(DW'(base + 100 + k), k == 0, 1'b0, gap, 1'b0);
        for (int k = 0; k < len; k++)
            drive_beat(DW'(base + k), k == 0, k == len - 1, gap, done_on_eop && (k == len - 1));
    endtask

    // Reference: a frame is accepted iff fewer than two frames await the reader at its sop;
    // only an exact-length frame becomes readable, holding its window pixels in raster order.
    task automatic model_frame(input int len, input int sop_at, input int base,
                               output int e_drop, output int e_err);
        bank_t b;
        int    idx;
        if (mdl_q.size() >= 2) begin
            e_drop = 1;
            e_err  = 0;
            return;
        end
        e_drop = 0;
        e_err  = ((sop_at > 0) ? 1 : 0) + ((len != TOT) ? 1 : 0);
        if (len == TOT) begin
            idx = 0;
            for (int k = 0; k < TOT; k++) begin
                if ((k % IW) >= WX && (k % IW) < WX + WW && (k / IW) >= WY && (k / IW) < WY + WH) begin
                    b[idx] = DW'(base + k);
                    idx++;
                end
            end
            mdl_q.push_back(b);
        end
    endtask

    task automatic model_pop();
        if (mdl_q.size() > 0) begin
            mdl_q.delete(0);
            mdl_rd++;
        end
    endtask

    task automatic do_rd_done();
        @(negedge clk);
        bus.rd_done = 1'b1;
        model_pop();
        @(negedge clk);
        bus.rd_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.din_vld = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0;
        bus.rd_en = 1'b0;   bus.rd_done = 1'b0; bus.rd_addr = '0; bus.din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_q.delete();
        mdl_rd = 0;
    endtask

    task automatic read_addr(input int a, output logic [DW-1:0] d, output logic v);
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(a);
        @(negedge clk);
        bus.rd_en = 1'b0;
        d = bus.dout;
        v = bus.dout_vld;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_rdy"},  bus.frame_rdy, (mdl_q.size() > 0) ? 1 : 0);
        chk({tag, "_bank"}, bus.rd_bank,   mdl_rd % 2);
    endtask

    task automatic check_bank(input string tag);
        logic [DW-1:0] d;
        logic          v;
        if (mdl_q.size() > 0) begin
            for (int a = 0; a < NPIX; a++) begin
                read_addr(a, d, v);
                chk($sformatf("%s_vld%0d", tag, a), v, 1);
                chk($sformatf("%s_d%0d", tag, a), d, mdl_q[0][a]);
            end
        end
    endtask

    task automatic run_frame(input bit pre, input int len, input int sop_at, input int base,
                             input int gap, input string tag, output int d_drop, output int d_err);
        int s_drop, s_err, e_drop, e_err;
        if (pre) do_rd_done();
        s_drop = n_drop;
        s_err  = n_err;
        model_frame(len, sop_at, base, e_drop, e_err);
        send_frame(len, sop_at, base, gap, 1'b0);
        idle(2);
        d_drop = n_drop - s_drop;
        d_err  = n_err - s_err;
        chk({tag, "_drop"}, d_drop, e_drop);
        chk({tag, "_err"},  d_err,  e_err);
        check_state(tag);
        check_bank(tag);
    endtask

    initial begin
        logic [DW-1:0] plan [NPIX];
        logic [DW-1:0] d;
        logic          v;
        int            dd, de, ed, ee;

        plan = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd18, 8'd19, 8'd20, 8'd21, 8'd26, 8'd27, 8'd28, 8'd29};
        tbl[0] = '{0, 48, -1,   0, 1, 1, 0, 0, 0};
        tbl[1] = '{0, 48, -1,  60, 0, 1, 0, 0, 0};
        tbl[2] = '{0, 48, -1, 120, 2, 1, 0, 1, 0};
        tbl[3] = '{1, 48, -1,   0, 0, 1, 1, 0, 0};
        tbl[4] = '{1, 40, -1,  30, 0, 1, 0, 0, 1};
        tbl[5] = '{1, 48, 20,  90, 2, 1, 1, 0, 1};
        tbl[6] = '{1,  1, -1,   5, 0, 0, 0, 0, 1};
        tbl[7] = '{1, 55, -1,   3, 2, 0, 0, 0, 1};
        tbl[8] = '{0, 48, -1,  17, 2, 1, 0, 0, 0};

        bus.din = '0; bus.din_vld = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0;
        bus.rd_addr = '0; bus.rd_en = 1'b0; bus.rd_done = 1'b0;
        do_reset();

        chk("rst_rdy",  bus.frame_rdy, 0);
        chk("rst_bank", bus.rd_bank,   0);
        chk("rst_vld",  bus.dout_vld,  0);
        chk("rst_dout", bus.dout,      0);

        // frame_rdy rises only after the eop beat has been sampled
        model_frame(TOT, -1, 0, ed, ee);
        for (int k = 0; k < TOT; k++) drive_beat(DW'(k), k == 0, k == TOT - 1, 0, 1'b0);
        chk("p1_rdy_pre", bus.frame_rdy, 0);
        idle(1);
        chk("p1_rdy_post", bus.frame_rdy, 1);
        for (int a = 0; a < NPIX; a++) begin
            read_addr(a, d, v);
            chk($sformatf("p1_vld%0d", a), v, 1);
            chk($sformatf("p1_d%0d", a), d, plan[a]);
        end
        idle(1);
        chk("p1_vld_fall", bus.dout_vld, 0);
        chk("p1_hold",     bus.dout,     29);
        read_addr(13, d, v);
        chk("oob_rdy", bus.frame_rdy, 1);
        read_addr(5, d, v);
        chk("oob_after", d, 19);
        do_rd_done();
        check_state("rel1");
        read_addr(0, d, v);
        chk("empty_vld",  v, 0);
        chk("empty_hold", d, 19);
        do_rd_done();
        chk("empty_done_bank", bus.rd_bank, 1);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i].pre_done, tbl[i].len, tbl[i].sop_at, tbl[i].base, tbl[i].gap,
                      $sformatf("t%0d", i), dd, de);
            chk($sformatf("t%0d_trdy", i),  bus.frame_rdy, tbl[i].exp_rdy);
            chk($sformatf("t%0d_tbank", i), bus.rd_bank,   tbl[i].exp_bank);
            chk($sformatf("t%0d_tdrop", i), dd, tbl[i].exp_drop);
            chk($sformatf("t%0d_terr", i),  de, tbl[i].exp_err);
        end

        do_reset();
        for (int i = 0; i < 30; i++) begin
            int len, sop_at;
            len    = ($urandom_range(0, 3) < 3) ? TOT : int'($urandom_range(1, 60));
            sop_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 47)) : -1;
            run_frame(1'($urandom_range(0, 1)), len, sop_at, int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 2)), $sformatf("r%0d", i), dd, de);
        end

        // release of bank 0 in the same cycle as bank 1 completes
        do_reset();
        run_frame(1'b0, TOT, -1, 11, 0, "co_a", dd, de);
        model_pop();
        model_frame(TOT, -1, 40, ed, ee);
        send_frame(TOT, -1, 40, 0, 1'b1);
        idle(2);
        chk("co_rdy",  bus.frame_rdy, 1);
        chk("co_bank", bus.rd_bank,   1);
        check_bank("co_b");

        for (int k = 0; k < 20; k++) drive_beat(DW'(k), k == 0, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.din_vld = 1'b0; bus.din_sop = 1'b0;
        @(negedge clk);
        chk("mrst_dout", bus.dout,       0);
        chk("mrst_vld",  bus.dout_vld,   0);
        chk("mrst_rdy",  bus.frame_rdy,  0);
        chk("mrst_bank", bus.rd_bank,    0);
        chk("mrst_drop", bus.frame_drop, 0);
        chk("mrst_err",  bus.err_len,    0);
        rst_n = 1'b1;
        mdl_q.delete();
        mdl_rd = 0;
        run_frame(1'b0, 40, -1, 0, 0, "mrst_short", dd, de);
        chk("mrst_short_err", de, 1);
        run_frame(1'b0, TOT, -1, 77, 0, "mrst_good", dd, de);
        chk("mrst_good_rdy",  bus.frame_rdy, 1);
        chk("mrst_good_bank", bus.rd_bank,   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
